regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Integer register file: the responder for the ID-stage operand decoders.
- Serves two combinational read ports (raddr + re in, rdata out) and one write-back port.
- Adds a per-register pending-write scoreboard, so ID can detect RAW hazards on registers whose results are still in flight.
- Sits between ID (read and issue side) and WB (write side) of the RV32 core.

Parameters:
- NUM_REGS, 32, number of architectural registers; index 0 is hardwired zero.
- PEND_W, 2, width of each per-register pending-write counter; max in-flight writes per register = 2^PEND_W-1.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- reg1_raddr_i  in  `RADDR_WIDTH  read port 1 address.
- reg1_re_i  in  1  read port 1 enable (`READ_ENABLE`).
- reg1_rdata_o  out  `RDATA_WIDTH  read port 1 data.
- reg2_raddr_i, reg2_re_i, reg2_rdata_o: same as port 1, for port 2.
- reg1_busy_o  out  1  port-1 register has a pending write.
- reg2_busy_o  out  1  port-2 register has a pending write.
- wb_we_i  in  1  write-back enable (`WRITE_ENABLE`).
- wb_waddr_i  in  `RADDR_WIDTH  write-back address.
- wb_wdata_i  in  `RDATA_WIDTH  write-back data.
- iss_we_i  in  1  ID issues an instruction that will write iss_waddr_i.
- iss_waddr_i  in  `RADDR_WIDTH  issued destination register.
- iss_full_o  out  1  pending counter of iss_waddr_i is saturated; ID must stall.

Behaviour:
- Reset (async, rst=1): every register cleared to 0; every pending counter cleared to 0. Consequently all rdata_o read 0, busy_o = 0 and iss_full_o = 0 while in reset.
- Write: on posedge clk, if wb_we_i and wb_waddr_i != 0, regs[wb_waddr_i] <= wb_wdata_i. Writes to x0 are dropped.
- Read is combinational, zero latency. Per port, rdata_o is:
  - 0 if re_i is disabled.
  - 0 if raddr_i == 0.
  - wb_wdata_i if wb_we_i and wb_waddr_i == raddr_i (write-through bypass).
  - otherwise regs[raddr_i].
- Both ports may read the same address; both may be bypassed in the same cycle.
- Scoreboard, per register r != 0, counter pend[r] updated on posedge:
  - inc = iss_we_i && iss_waddr_i == r && !iss_full_o
  - dec = wb_we_i && wb_waddr_i == r && pend[r] != 0
  - inc && dec: unchanged. inc only: +1. dec only: -1.
  - Write-back with pend[r] == 0 still writes data; the counter stays 0 (no underflow).
  - x0 is never tracked: pend[0] stays 0, issue to x0 is ignored, iss_full_o = 0 for x0.
- iss_full_o = iss_we_i && pend[iss_waddr_i] == all-ones && !(wb_we_i && wb_waddr_i == iss_waddr_i). A same-cycle retirement frees a slot. A refused issue does not increment.
- busy_o = re_i && raddr_i != 0 && pend[raddr_i] != 0 && !(wb_we_i && wb_waddr_i == raddr_i && pend[raddr_i] == 1). The last pending write retiring this cycle is covered by the bypass.
- Reset asserted mid-operation discards all pending counts immediately. The pipeline flush is the core's responsibility.

Optional Feature:
- Macro REGFILE_DBG_PORT_EN.
- Defined: adds input dbg_raddr_i (`RADDR_WIDTH`) and output dbg_rdata_o (`RDATA_WIDTH`), a third combinational read port for the debug module. It has no bypass (returns committed state only), x0 reads 0, and it is 0 during reset.
- Undefined: the ports are absent and there is no logic.

Decomposition:
- defines.v supplies: `RADDR_WIDTH`, `RDATA_WIDTH`, `READ_ENABLE`/`READ_DISABLE`, `WRITE_ENABLE`/`WRITE_DISABLE`, `ZERO_REG`.
- Add `REG_NUM` (32) and `PEND_WIDTH` (2) to defines.v.
- One natural sub-module: regfile_rport, a single read port (zero/enable/bypass mux plus busy term), instantiated twice.

Test Plan:
- Reset, then read x5 and x0 on both ports -> rdata 0, busy 0.
- Write x5=0xDEADBEEF with reg1_raddr=5 in the same cycle -> reg1_rdata=0xDEADBEEF that cycle (bypass); still 0xDEADBEEF next cycle with wb_we=0.
- Write x0=0x1234, then read x0 -> 0. Issue to x0 -> iss_full 0, busy on x0 0.
- Issue x7 three times -> pend=3. Fourth issue -> iss_full=1, count stays 3. Fourth issue plus a same-cycle WB to x7 -> iss_full=0, count stays 3.
- pend[x9]=1, WB x9=0x55 with reg2_raddr=9 -> busy 0, rdata 0x55. Next cycle busy 0.
- Issue x3 twice, assert rst mid-flight -> busy 0, regs 0. WB x3 after reset -> pend stays 0, data written.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared types and helpers for the regfile_sb register file / scoreboard.
`include "defines.v"

package regfile_sb_pkg;

  localparam int AW = `RADDR_WIDTH;
  localparam int DW = `RDATA_WIDTH;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;

  // True when the write-back port targets the given address this cycle.
  function automatic logic addr_hit(input logic we, input addr_t waddr, input addr_t raddr);
    return (we == `WRITE_ENABLE) && (waddr == raddr);
  endfunction

endpackage

// File: rtl/defines.v
// Shared core-wide widths and encodings for the register file and its clients.
`ifndef REGFILE_DEFINES_V
`define REGFILE_DEFINES_V

`define RADDR_WIDTH   5
`define RDATA_WIDTH   32
`define READ_ENABLE   1'b1
`define READ_DISABLE  1'b0
`define WRITE_ENABLE  1'b1
`define WRITE_DISABLE 1'b0
`define ZERO_REG      5'h0
`define REG_NUM       32
`define PEND_WIDTH    2

`endif

// File: rtl/regfile_sb_rport.sv
// One combinational read port: zero/enable/bypass data mux plus the RAW busy term.
`include "defines.v"

module regfile_sb_rport
  import regfile_sb_pkg::*;
#(
  parameter int PEND_W = `PEND_WIDTH
) (
  input  logic              rst,
  input  addr_t             raddr,
  input  logic              re,
  input  logic              wb_we,
  input  addr_t             wb_waddr,
  input  data_t             wb_wdata,
  input  data_t             reg_data,
  input  logic [PEND_W-1:0] pend_cnt,
  output data_t             rdata,
  output logic              busy
);

  logic active;
  logic hit;

  assign active = !rst && (re == `READ_ENABLE) && (raddr != `ZERO_REG);
  assign hit    = addr_hit(wb_we, wb_waddr, raddr);

  always_comb begin
    rdata = '0;
    if (active) begin
      rdata = hit ? wb_wdata : reg_data;
    end
  end

  // The last in-flight write retiring now is already visible through the bypass.
  assign busy = active && (pend_cnt != '0) && !(hit && pend_cnt == PEND_W'(1));

endmodule

// File: rtl/regfile_sb.sv
// RV32 integer register file with per-register pending-write scoreboard.
// Optional debug read port enabled by defining REGFILE_DBG_PORT_EN.
`include "defines.v"

module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int NUM_REGS = `REG_NUM,
  parameter int PEND_W   = `PEND_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [`RADDR_WIDTH-1:0] reg1_raddr_i,
  input  logic                    reg1_re_i,
  output logic [`RDATA_WIDTH-1:0] reg1_rdata_o,
  input  logic [`RADDR_WIDTH-1:0] reg2_raddr_i,
  input  logic                    reg2_re_i,
  output logic [`RDATA_WIDTH-1:0] reg2_rdata_o,
  output logic                    reg1_busy_o,
  output logic                    reg2_busy_o,
  input  logic                    wb_we_i,
  input  logic [`RADDR_WIDTH-1:0] wb_waddr_i,
  input  logic [`RDATA_WIDTH-1:0] wb_wdata_i,
  input  logic                    iss_we_i,
  input  logic [`RADDR_WIDTH-1:0] iss_waddr_i,
  output logic                    iss_full_o
`ifdef REGFILE_DBG_PORT_EN
  ,
  input  logic [`RADDR_WIDTH-1:0] dbg_raddr_i,
  output logic [`RDATA_WIDTH-1:0] dbg_rdata_o
`endif
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  data_t             regs      [NUM_REGS];
  logic [PEND_W-1:0] pend      [NUM_REGS];
  logic [PEND_W-1:0] pend_next [NUM_REGS];

  // A retirement to the same register in this cycle frees a slot for the issue.
  assign iss_full_o = (iss_we_i == `WRITE_ENABLE) && (iss_waddr_i != `ZERO_REG) &&
                      (pend[iss_waddr_i] == PEND_MAX) &&
                      !addr_hit(wb_we_i, wb_waddr_i, iss_waddr_i);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign pend_next[gi] = '0;
      end else begin : g_track
        logic inc;
        logic dec;
        assign inc = (iss_we_i == `WRITE_ENABLE) && (iss_waddr_i == AW'(gi)) && !iss_full_o;
        assign dec = (wb_we_i == `WRITE_ENABLE) && (wb_waddr_i == AW'(gi)) && (pend[gi] != '0);
        assign pend_next[gi] = (inc && !dec) ? pend[gi] + PEND_W'(1) :
                               (dec && !inc) ? pend[gi] - PEND_W'(1) : pend[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
    end else begin
      if ((wb_we_i == `WRITE_ENABLE) && (wb_waddr_i != `ZERO_REG)) begin
        regs[wb_waddr_i] <= wb_wdata_i;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        pend[i] <= pend_next[i];
      end
    end
  end

  regfile_sb_rport #(.PEND_W(PEND_W)) u_rport1 (
    .rst      (rst),
    .raddr    (reg1_raddr_i),
    .re       (reg1_re_i),
    .wb_we    (wb_we_i),
    .wb_waddr (wb_waddr_i),
    .wb_wdata (wb_wdata_i),
    .reg_data (regs[reg1_raddr_i]),
    .pend_cnt (pend[reg1_raddr_i]),
    .rdata    (reg1_rdata_o),
    .busy     (reg1_busy_o)
  );

  regfile_sb_rport #(.PEND_W(PEND_W)) u_rport2 (
    .rst      (rst),
    .raddr    (reg2_raddr_i),
    .re       (reg2_re_i),
    .wb_we    (wb_we_i),
    .wb_waddr (wb_waddr_i),
    .wb_wdata (wb_wdata_i),
    .reg_data (regs[reg2_raddr_i]),
    .pend_cnt (pend[reg2_raddr_i]),
    .rdata    (reg2_rdata_o),
    .busy     (reg2_busy_o)
  );

`ifdef REGFILE_DBG_PORT_EN
  // Debug sees committed state only, never the write-back bypass.
  assign dbg_rdata_o = (rst || dbg_raddr_i == `ZERO_REG) ? '0 : regs[dbg_raddr_i];
`endif

endmodule
